// File: rtl/trdb_pkg.sv
// Shared trace-debugger constants and the packet arbiter state encoding.
package trdb_pkg;

  localparam int unsigned PTYPE_LEN   = 4;
  localparam int unsigned P_LEN       = 7;
  localparam int unsigned PAYLOAD_LEN = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/trdb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, cyclically.
module trdb_rr_arbiter #(
  parameter int unsigned N_SRC = 2,
  parameter int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_SRC-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < N_SRC; off++) begin
      for (int unsigned k = 0; k < N_SRC; k++) begin
        if (!found && req[k] && (k == (32'(ptr) + off) % N_SRC)) begin
          found    = 1'b1;
          grant[k] = 1'b1;
          idx      = IDX_W'(k);
        end
      end
    end
    valid = found;
  end

endmodule

// File: rtl/trdb_packet_arbiter.sv
// Round-robin packet arbiter serialising trace packets as header + payload beats.
// Optional macro TRDB_ARB_SRCID_EN adds the granted source index to the header.
module trdb_packet_arbiter
  import trdb_pkg::*;
#(
  parameter int unsigned N_SRC  = 2,
  parameter int unsigned BEAT_W = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_SRC-1:0]              src_valid_i,
  output logic [N_SRC-1:0]              src_ready_o,
  input  logic [N_SRC*PTYPE_LEN-1:0]    src_type_i,
  input  logic [N_SRC*P_LEN-1:0]        src_length_i,
  input  logic [N_SRC*PAYLOAD_LEN-1:0]  src_payload_i,
  output logic                          beat_valid_o,
  input  logic                          beat_ready_i,
  output logic [BEAT_W-1:0]             beat_data_o,
  output logic                          beat_last_o,
  output logic                          busy_o
);

  localparam int unsigned IDX_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned BPB       = BEAT_W / 8;
  localparam int unsigned MAX_BYTES = PAYLOAD_LEN / 8;
  localparam int unsigned MAX_BEATS = (MAX_BYTES + BPB - 1) / BPB;
  localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);
  localparam int unsigned HOLD_W    = MAX_BEATS * BEAT_W;

  arb_state_e state_q, state_d;

  logic [IDX_W-1:0]     rr_q;
  logic [CNT_W-1:0]     cnt_q, nb_q, nb_d;
  logic [PTYPE_LEN-1:0] type_q, sel_type;
  logic [P_LEN-1:0]     len_q, sel_len, clamp_len;
  logic [HOLD_W-1:0]    pay_q, masked_pay;
  logic [PAYLOAD_LEN-1:0] sel_pay;
  logic [N_SRC-1:0]     grant;
  logic [IDX_W-1:0]     idx;
  logic                 any_req;
  logic                 capture;
  logic                 payload_last;
`ifdef TRDB_ARB_SRCID_EN
  logic [IDX_W-1:0]     src_q;
`endif

  trdb_rr_arbiter #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (src_valid_i),
    .ptr   (rr_q),
    .grant (grant),
    .idx   (idx),
    .valid (any_req)
  );

  // Select the granted source, clamp its length and zero bytes past the length
  // at capture so the payload beats can be driven straight from the register.
  always_comb begin
    sel_type   = '0;
    sel_len    = '0;
    sel_pay    = '0;
    masked_pay = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (grant[i]) begin
        sel_type = src_type_i[i*PTYPE_LEN +: PTYPE_LEN];
        sel_len  = src_length_i[i*P_LEN +: P_LEN];
        sel_pay  = src_payload_i[i*PAYLOAD_LEN +: PAYLOAD_LEN];
      end
    end
    clamp_len = (32'(sel_len) > MAX_BYTES) ? P_LEN'(MAX_BYTES) : sel_len;
    for (int unsigned b = 0; b < MAX_BYTES; b++) begin
      if (b < 32'(clamp_len)) masked_pay[b*8 +: 8] = sel_pay[b*8 +: 8];
    end
    nb_d = CNT_W'((32'(clamp_len) + BPB - 1) / BPB);
  end

  assign payload_last = (cnt_q == nb_q - CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    src_ready_o  = '0;
    beat_valid_o = 1'b0;
    beat_data_o  = '0;
    beat_last_o  = 1'b0;
    busy_o       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (any_req) begin
          capture     = 1'b1;
          src_ready_o = rst_ni ? grant : '0;
          state_d     = HEADER;
        end
      end
      HEADER: begin
        beat_valid_o                   = 1'b1;
        beat_data_o[0 +: PTYPE_LEN]    = type_q;
        beat_data_o[PTYPE_LEN +: P_LEN] = len_q;
`ifdef TRDB_ARB_SRCID_EN
        beat_data_o[PTYPE_LEN+P_LEN +: IDX_W] = src_q;
`endif
        beat_last_o = (nb_q == '0);
        if (beat_ready_i) state_d = (nb_q == '0) ? IDLE : PAYLOAD;
      end
      PAYLOAD: begin
        beat_valid_o = 1'b1;
        for (int unsigned b = 0; b < MAX_BEATS; b++) begin
          if (cnt_q == CNT_W'(b)) beat_data_o = pay_q[b*BEAT_W +: BEAT_W];
        end
        beat_last_o = payload_last;
        if (beat_ready_i && payload_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      cnt_q  <= '0;
      nb_q   <= '0;
      type_q <= '0;
      len_q  <= '0;
      pay_q  <= '0;
`ifdef TRDB_ARB_SRCID_EN
      src_q  <= '0;
`endif
    end else if (capture) begin
      rr_q   <= (idx == IDX_W'(N_SRC - 1)) ? '0 : idx + IDX_W'(1);
      cnt_q  <= '0;
      nb_q   <= nb_d;
      type_q <= sel_type;
      len_q  <= clamp_len;
      pay_q  <= masked_pay;
`ifdef TRDB_ARB_SRCID_EN
      src_q  <= idx;
`endif
    end else if (state_q == PAYLOAD && beat_ready_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_trdb_packet_arbiter.sv
// Directed self-checking bench for trdb_packet_arbiter (N_SRC=2, BEAT_W=32).
module tb_trdb_packet_arbiter;
  import trdb_pkg::*;

  localparam int unsigned N = 2;
`ifdef TRDB_ARB_SRCID_EN
  localparam logic [31:0] S1 = 32'h800;
`else
  localparam logic [31:0] S1 = 32'h0;
`endif

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [N-1:0]               src_valid = '0;
  logic [N-1:0]               src_ready;
  logic [N*PTYPE_LEN-1:0]     src_type = '0;
  logic [N*P_LEN-1:0]         src_length = '0;
  logic [N*PAYLOAD_LEN-1:0]   src_payload = '0;
  logic                       beat_valid;
  logic                       beat_ready = 1'b1;
  logic [31:0]                beat_data;
  logic                       beat_last;
  logic                       busy;

  int checks = 0;
  int failures = 0;

  trdb_packet_arbiter #(.N_SRC(N), .BEAT_W(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .src_valid_i   (src_valid),
    .src_ready_o   (src_ready),
    .src_type_i    (src_type),
    .src_length_i  (src_length),
    .src_payload_i (src_payload),
    .beat_valid_o  (beat_valid),
    .beat_ready_i  (beat_ready),
    .beat_data_o   (beat_data),
    .beat_last_o   (beat_last),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [3:0] t, input logic [6:0] l,
                         input logic [127:0] p);
    src_type[i*PTYPE_LEN +: PTYPE_LEN]        = t;
    src_length[i*P_LEN +: P_LEN]              = l;
    src_payload[i*PAYLOAD_LEN +: PAYLOAD_LEN] = p;
  endtask

  // advance one clock, land on the falling edge, let comb outputs settle
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [31:0] d, input logic l);
    check({tag, "_valid"}, 64'(beat_valid), 64'(1));
    check({tag, "_data"}, 64'(beat_data), 64'(d));
    check({tag, "_last"}, 64'(beat_last), 64'(l));
    check({tag, "_rdy0"}, 64'(src_ready), 64'(0));
  endtask

  initial begin
    // reset values
    @(negedge clk); #1;
    check("rst_ready", 64'(src_ready), 64'(0));
    check("rst_valid", 64'(beat_valid), 64'(0));
    check("rst_data", 64'(beat_data), 64'(0));
    check("rst_last", 64'(beat_last), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;

    // single packet, length 5, garbage above byte 4 must be masked
    step();
    set_src(0, 4'd2, 7'd5, 128'hDEADBEEF_CAFEF00D_99887755_44332211);
    src_valid = 2'b01; #1;
    check("p1_grant", 64'(src_ready), 64'(1));
    check("p1_idle_busy", 64'(busy), 64'(0));
    step(); src_valid = 2'b00; #1;
    beat("p1_hdr", 32'h52, 1'b0);
    check("p1_busy", 64'(busy), 64'(1));
    step(); beat("p1_b1", 32'h44332211, 1'b0);
    step(); beat("p1_b2", 32'h00000055, 1'b1);
    step();
    check("p1_done_valid", 64'(beat_valid), 64'(0));
    check("p1_done_busy", 64'(busy), 64'(0));

    // zero length from src1: header only
    set_src(1, 4'd1, 7'd0, 128'hFFFF);
    src_valid = 2'b10; #1;
    check("p2_grant", 64'(src_ready), 64'(2));
    step(); src_valid = 2'b00; #1;
    beat("p2_hdr", 32'h01 | S1, 1'b1);
    step();
    check("p2_done_busy", 64'(busy), 64'(0));

    // both sources continuously valid: grants alternate, 2 beats each
    set_src(0, 4'd3, 7'd4, 128'hFFFF_FFFF_A0A1A2A3);
    set_src(1, 4'd5, 7'd4, 128'hEEEE_EEEE_B0B1B2B3);
    src_valid = 2'b11; #1;
    for (int p = 0; p < 4; p++) begin
      if (p % 2 == 0) begin
        check("rr_grant0", 64'(src_ready), 64'(1));
        step(); beat("rr_hdr0", 32'h43, 1'b0);
        step(); beat("rr_pay0", 32'hA0A1A2A3, 1'b1);
      end else begin
        check("rr_grant1", 64'(src_ready), 64'(2));
        step(); beat("rr_hdr1", 32'h45 | S1, 1'b0);
        step(); beat("rr_pay1", 32'hB0B1B2B3, 1'b1);
      end
      step();
    end
    src_valid = 2'b00; #1;
    check("rr_idle", 64'(busy), 64'(0));

    // backpressure on payload beat 1 while src1 waits
    set_src(0, 4'd6, 7'd8, 128'h07060504_03020100);
    src_valid = 2'b01; #1;
    check("bp_grant", 64'(src_ready), 64'(1));
    step(); src_valid = 2'b10; #1;
    beat("bp_hdr", 32'h86, 1'b0);
    step(); beat_ready = 1'b0; #1;
    beat("bp_b1", 32'h03020100, 1'b0);
    for (int s = 0; s < 3; s++) begin
      step();
      beat("bp_stall", 32'h03020100, 1'b0);
    end
    beat_ready = 1'b1;
    step(); beat("bp_b2", 32'h07060504, 1'b1);
    step();
    check("bp_next_grant", 64'(src_ready), 64'(2));
    step(); src_valid = 2'b00; #1;
    beat("bp_hdr1", 32'h45 | S1, 1'b0);
    step(); beat("bp_pay1", 32'hB0B1B2B3, 1'b1);
    step();

    // overlong length clamps to 16 bytes / 4 beats
    set_src(0, 4'd7, 7'd19, 128'h1F1E1D1C_1B1A1918_17161514_13121110);
    src_valid = 2'b01; #1;
    check("ol_grant", 64'(src_ready), 64'(1));
    step(); src_valid = 2'b00; #1;
    beat("ol_hdr", 32'h107, 1'b0);
    step(); beat("ol_b1", 32'h13121110, 1'b0);
    step(); beat("ol_b2", 32'h17161514, 1'b0);
    step(); beat("ol_b3", 32'h1B1A1918, 1'b0);
    step(); beat("ol_b4", 32'h1F1E1D1C, 1'b1);
    step();
    check("ol_idle", 64'(busy), 64'(0));

    // reset mid-payload (rr pointer is 1 before reset)
    set_src(0, 4'd2, 7'd8, 128'h88776655_44332211);
    src_valid = 2'b01; #1;
    check("rs_grant", 64'(src_ready), 64'(1));
    step(); src_valid = 2'b00; #1;
    beat("rs_hdr", 32'h82, 1'b0);
    step(); beat("rs_b1", 32'h44332211, 1'b0);
    #1 rst_n = 1'b0; #1;
    check("rs_valid", 64'(beat_valid), 64'(0));
    check("rs_data", 64'(beat_data), 64'(0));
    check("rs_last", 64'(beat_last), 64'(0));
    check("rs_busy", 64'(busy), 64'(0));
    step(); rst_n = 1'b1;
    set_src(0, 4'd3, 7'd0, 128'h0);
    set_src(1, 4'd9, 7'd1, 128'hCCAB);
    src_valid = 2'b11; #1;
    check("rs_ptr0", 64'(src_ready), 64'(1));
    step(); src_valid = 2'b10; #1;
    beat("rs_hdr0", 32'h03, 1'b1);
    step();
    check("rs_grant1", 64'(src_ready), 64'(2));
    step(); src_valid = 2'b00; #1;
    beat("rs_hdr1", 32'h19 | S1, 1'b0);
    step(); beat("rs_pay1", 32'h000000AB, 1'b1);
    step();
    check("rs_end_busy", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
